// File: rtl/frame_ser_pkg.sv
// Shared types and constants for the frame serializer.
// Holds the FSM state encoding and the default header word.
package frame_ser_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_HDR     = 3'd2,
      S_LEN     = 3'd3,
      S_DATA    = 3'd4,
      S_CSUM    = 3'd5
   } state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA5;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_ser_buf.sv
// Channel word storage for one frame.
// One synchronous write port, one combinational read port.
module frame_ser_buf
   import frame_ser_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int N_CH   = 16,
   parameter int IDX_W  = idx_w(N_CH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [N_CH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_serializer.sv
// Collects channel words into a frame and streams it out as
// header, length, data words and an XOR checksum.
module frame_serializer
   import frame_ser_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int N_CH    = 16,
   parameter int TIMEOUT = 32,
   parameter logic [DATA_W-1:0] HDR_WORD = DATA_W'(HDR_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_sof,
   output logic              dout_eof,
   output logic              busy
);

   localparam int CNT_W = $clog2(N_CH + 1);
   localparam int IDX_W = idx_w(N_CH);
   localparam int IDL_W = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx;
   logic [IDL_W-1:0]  idle_q, idle_d, idle_nx;
   logic [DATA_W-1:0] csum_q, csum_d, rd_data;
   logic [IDX_W-1:0]  idx_q, idx_d, wr_addr;
   logic              en_q, en_d;
   logic              wr_en, accept, xfer;

   // en_q keeps din_ready low until the first edge after reset release
   assign en_d       = 1'b1;
   assign din_ready  = en_q &&
                       (state_q == S_IDLE || state_q == S_COLLECT);
   assign dout_valid = state_q inside {S_HDR, S_LEN, S_DATA, S_CSUM};
   assign busy       = (state_q != S_IDLE);
   assign accept     = din_valid && din_ready;
   assign xfer       = dout_valid && dout_ready;
   assign cnt_nx     = cnt_q + CNT_W'(1);
   assign idle_nx    = idle_q + IDL_W'(1);

   frame_ser_buf #(
      .DATA_W (DATA_W),
      .N_CH   (N_CH),
      .IDX_W  (IDX_W)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (din),
      .raddr (idx_q),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idle_q  <= '0;
         csum_q  <= '0;
         idx_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idle_d   = idle_q;
      csum_d   = csum_q;
      idx_d    = idx_q;
      wr_en    = 1'b0;
      wr_addr  = cnt_q[IDX_W-1:0];
      dout     = '0;
      dout_sof = 1'b0;
      dout_eof = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               cnt_d   = CNT_W'(1);
               idle_d  = '0;
               csum_d  = din;
               state_d = (N_CH == 1) ? S_HDR : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (accept) begin
               wr_en  = 1'b1;
               cnt_d  = cnt_nx;
               idle_d = '0;
               csum_d = csum_q ^ din;
               if (cnt_nx == CNT_W'(N_CH)) begin
                  state_d = S_HDR;
               end
            end else begin
               idle_d = idle_nx;
               if (idle_nx == IDL_W'(TIMEOUT)) begin
                  state_d = S_HDR;
               end
            end
         end
         S_HDR: begin
            dout     = HDR_WORD;
            dout_sof = 1'b1;
            if (xfer) begin
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            dout = DATA_W'(cnt_q);
            if (xfer) begin
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            dout = rd_data;
            if (xfer) begin
               if (CNT_W'(idx_q) + CNT_W'(1) == cnt_q) begin
                  state_d = S_CSUM;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_CSUM: begin
            dout     = csum_q ^ DATA_W'(cnt_q);
            dout_eof = 1'b1;
            if (xfer) begin
               cnt_d   = '0;
               idle_d  = '0;
               csum_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
